// File: rtl/garbage_manager.sv
// Garbage-line bookkeeping between the link and the local playfield:
// converts the opponent's cumulative counter into pending rows, cancels
// them against local attacks, and hands rows to the playfield.
//
//  state  | meaning
//  IDLE   | game not running, all counters held at zero
//  RUN    | normal play: accumulate incoming, cancel/send on locks
//  INSERT | insertion request outstanding, rows/hole held until ready
module garbage_manager #(
  parameter int GBG_BITS       = 4,
  parameter int PEND_BITS      = 5,
  parameter int MAX_PENDING    = 20,
  parameter int MAX_INSERT     = 4,
  parameter int PLAYFIELD_COLS = 10
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 game_active,
  input  logic                 piece_locked,
  input  logic [2:0]           lines_cleared,
  input  logic [GBG_BITS-1:0]  opponent_garbage,
  input  logic                 update_opponent_data,
  input  logic                 insert_ready,
  output logic [GBG_BITS-1:0]  garbage,
  output logic [PEND_BITS-1:0] pending_garbage,
  output logic                 insert_valid,
  output logic [2:0]           insert_rows,
  output logic [3:0]           insert_hole
);

  localparam int SUM_W = ((PEND_BITS > GBG_BITS) ? PEND_BITS : GBG_BITS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, INSERT} state_t;

  state_t               state, state_nxt;
  logic [GBG_BITS-1:0]  last_opp, last_opp_nxt, delta, garbage_nxt;
  logic [PEND_BITS-1:0] pending_nxt, pend_in, pend_after;
  logic [SUM_W-1:0]     pend_sum;
  logic [2:0]           attack, cancel, rows_sel, rows_nxt;
  logic [3:0]           lfsr, hole_sel, hole_nxt;
  logic                 valid_nxt;

  // Shared arithmetic: incoming delta with saturation, attack table, cancel.
  always_comb begin
    delta    = opponent_garbage - last_opp;
    pend_sum = SUM_W'(pending_garbage) + SUM_W'(delta);
    pend_in  = pending_garbage;
    if (update_opponent_data) begin
      pend_in = (pend_sum > SUM_W'(MAX_PENDING)) ? PEND_BITS'(MAX_PENDING)
                                                 : pend_sum[PEND_BITS-1:0];
    end
    case (lines_cleared)
      3'd2:    attack = 3'd1;
      3'd3:    attack = 3'd2;
      3'd4:    attack = 3'd4;
      default: attack = 3'd0;
    endcase
    cancel     = (PEND_BITS'(attack) < pend_in) ? attack : pend_in[2:0];
    pend_after = pend_in - PEND_BITS'(cancel);
    rows_sel   = (pend_after > PEND_BITS'(MAX_INSERT)) ? 3'(MAX_INSERT)
                                                       : pend_after[2:0];
    hole_sel   = (lfsr >= 4'(PLAYFIELD_COLS)) ? lfsr - 4'(PLAYFIELD_COLS) : lfsr;
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state;
    garbage_nxt  = garbage;
    pending_nxt  = pending_garbage;
    last_opp_nxt = last_opp;
    valid_nxt    = insert_valid;
    rows_nxt     = insert_rows;
    hole_nxt     = insert_hole;
    if (!game_active) begin
      state_nxt    = IDLE;
      garbage_nxt  = '0;
      pending_nxt  = '0;
      last_opp_nxt = '0;
      valid_nxt    = 1'b0;
      rows_nxt     = '0;
      hole_nxt     = '0;
    end else begin
      case (state)
        IDLE: state_nxt = RUN;
        RUN: begin
          if (update_opponent_data) last_opp_nxt = opponent_garbage;
          pending_nxt = pend_in;
          if (piece_locked) begin
            pending_nxt = pend_after;
            garbage_nxt = garbage + GBG_BITS'(attack - cancel);
            if (lines_cleared == 3'd0 && pend_after != '0) begin
              state_nxt = INSERT;
              valid_nxt = 1'b1;
              rows_nxt  = rows_sel;
              hole_nxt  = hole_sel;
            end
          end
        end
        INSERT: begin
          // locks are ignored here; only the handshake decrements pending
          if (update_opponent_data) last_opp_nxt = opponent_garbage;
          pending_nxt = pend_in;
          if (insert_ready) begin
            pending_nxt = pend_in - PEND_BITS'(insert_rows);
            valid_nxt   = 1'b0;
            state_nxt   = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Free-running x^4+x^3+1 LFSR for hole selection; never reaches zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) lfsr <= 4'b0001;
    else        lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= IDLE;
      garbage         <= '0;
      pending_garbage <= '0;
      last_opp        <= '0;
      insert_valid    <= 1'b0;
      insert_rows     <= '0;
      insert_hole     <= '0;
    end else begin
      state           <= state_nxt;
      garbage         <= garbage_nxt;
      pending_garbage <= pending_nxt;
      last_opp        <= last_opp_nxt;
      insert_valid    <= valid_nxt;
      insert_rows     <= rows_nxt;
      insert_hole     <= hole_nxt;
    end
  end

endmodule
